// File: rtl/ntt_butterfly_sched.sv
// ============================================================================
// ntt_butterfly_sched: walks all NTT layers (CT forward / GS inverse), issuing
// read/twiddle addresses per butterfly and delayed write-back addresses.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ntt_butterfly_sched #(
  parameter int LOG_N = 8,
  parameter int LAT   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             inverse_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [LOG_N-1:0] rd_addr_a_o,
  output logic [LOG_N-1:0] rd_addr_b_o,
  output logic [LOG_N-1:0] tw_addr_o,
  output logic             sel_butterfly_o,
  output logic             wr_en_o,
  output logic [LOG_N-1:0] wr_addr_a_o,
  output logic [LOG_N-1:0] wr_addr_b_o
);

  localparam int N  = 1 << LOG_N;
  localparam int LW = $clog2(LOG_N + 1);
  localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               inv_q, inv_d;
  logic [LOG_N-1:0]   j_q, j_d;
  logic [LOG_N-1:0]   len_q, len_d;
  logic [LOG_N-1:0]   k_q, k_d;
  logic [LOG_N-2:0]   bf_q, bf_d;
  logic [LW-1:0]      layer_q, layer_d;
  logic [DW-1:0]      drain_q, drain_d;
  logic [LAT-1:0]     wb_en_q, wb_en_d;
  logic [LOG_N-1:0]   wb_a_q [LAT];
  logic [LOG_N-1:0]   wb_a_d [LAT];
  logic [LOG_N-1:0]   wb_b_q [LAT];
  logic [LOG_N-1:0]   wb_b_d [LAT];

  logic               hs;
  logic [LOG_N-1:0]   j_inc;
  logic               group_end;
  logic               last_bf;
  logic               last_layer;

  assign hs         = (state_q == S_ISSUE) && ready_i;
  assign j_inc      = j_q + 1'b1;
  // Crossing into the len bit means the current group is exhausted.
  assign group_end  = |(j_inc & len_q);
  assign last_bf    = &bf_q;
  assign last_layer = (layer_q == LW'(LOG_N - 1));

  always_comb begin
    state_d = state_q;
    inv_d   = inv_q;
    j_d     = j_q;
    len_d   = len_q;
    k_d     = k_q;
    bf_d    = bf_q;
    layer_d = layer_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_ISSUE;
          inv_d   = inverse_i;
          j_d     = '0;
          bf_d    = '0;
          layer_d = '0;
          len_d   = inverse_i ? LOG_N'(1) : LOG_N'(N / 2);
          k_d     = inverse_i ? LOG_N'(N - 1) : LOG_N'(1);
        end
      end
      S_ISSUE: begin
        if (hs) begin
          bf_d = bf_q + 1'b1;
          j_d  = group_end ? (j_inc + len_q) : j_inc;
          // k stops on its final value so it never wraps past 0 / N-1.
          if (group_end && !(last_bf && last_layer)) begin
            k_d = inv_q ? (k_q - 1'b1) : (k_q + 1'b1);
          end
          if (last_bf) begin
            state_d = S_DRAIN;
            drain_d = '0;
            j_d     = '0;
            layer_d = layer_q + 1'b1;
            if (!last_layer) begin
              len_d = inv_q ? (len_q << 1) : (len_q >> 1);
            end
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == DW'(LAT - 1)) begin
          state_d = (layer_q == LW'(LOG_N)) ? S_DONE : S_ISSUE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wb_en_d    = '0;
    wb_en_d[0] = hs;
    wb_a_d[0]  = j_q;
    wb_b_d[0]  = j_q + len_q;
    for (int i = 1; i < LAT; i++) begin
      wb_en_d[i] = wb_en_q[i-1];
      wb_a_d[i]  = wb_a_q[i-1];
      wb_b_d[i]  = wb_b_q[i-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      inv_q   <= 1'b0;
      j_q     <= '0;
      len_q   <= '0;
      k_q     <= '0;
      bf_q    <= '0;
      layer_q <= '0;
      drain_q <= '0;
      wb_en_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        wb_a_q[i] <= '0;
        wb_b_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      inv_q   <= inv_d;
      j_q     <= j_d;
      len_q   <= len_d;
      k_q     <= k_d;
      bf_q    <= bf_d;
      layer_q <= layer_d;
      drain_q <= drain_d;
      wb_en_q <= wb_en_d;
      for (int i = 0; i < LAT; i++) begin
        wb_a_q[i] <= wb_a_d[i];
        wb_b_q[i] <= wb_b_d[i];
      end
    end
  end

  assign busy_o          = (state_q != S_IDLE);
  assign done_o          = (state_q == S_DONE);
  assign valid_o         = (state_q == S_ISSUE);
  assign rd_addr_a_o     = valid_o ? j_q : '0;
  assign rd_addr_b_o     = valid_o ? (j_q + len_q) : '0;
  assign tw_addr_o       = valid_o ? k_q : '0;
  assign sel_butterfly_o = inv_q;
  assign wr_en_o         = wb_en_q[LAT-1];
  assign wr_addr_a_o     = wb_a_q[LAT-1];
  assign wr_addr_b_o     = wb_b_q[LAT-1];

endmodule

`default_nettype wire

// File: tb/tb_ntt_butterfly_sched.sv
// ============================================================================
// tb_ntt_butterfly_sched: checks the scheduler against a loop-nest NTT model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ntt_butterfly_sched;

  localparam int LOG_N = 8;
  localparam int LAT   = 4;
  localparam int N     = 1 << LOG_N;
  localparam int HALF  = N / 2;
  localparam int TOTAL = LOG_N * HALF;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic             inverse_i;
  logic             busy_o;
  logic             done_o;
  logic             valid_o;
  logic             ready_i;
  logic [LOG_N-1:0] rd_addr_a_o;
  logic [LOG_N-1:0] rd_addr_b_o;
  logic [LOG_N-1:0] tw_addr_o;
  logic             sel_butterfly_o;
  logic             wr_en_o;
  logic [LOG_N-1:0] wr_addr_a_o;
  logic [LOG_N-1:0] wr_addr_b_o;

  ntt_butterfly_sched #(.LOG_N(LOG_N), .LAT(LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .inverse_i(inverse_i),
    .busy_o(busy_o), .done_o(done_o), .valid_o(valid_o), .ready_i(ready_i),
    .rd_addr_a_o(rd_addr_a_o), .rd_addr_b_o(rd_addr_b_o), .tw_addr_o(tw_addr_o),
    .sel_butterfly_o(sel_butterfly_o), .wr_en_o(wr_en_o),
    .wr_addr_a_o(wr_addr_a_o), .wr_addr_b_o(wr_addr_b_o)
  );

  always #5 clk_i = ~clk_i;

  int tests  = 0;
  int failed = 0;
  int exp_a[$];
  int exp_b[$];
  int exp_t[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference butterfly order straight from the layer/group/pair definition.
  function automatic void build(input bit inv);
    int k, len;
    exp_a.delete(); exp_b.delete(); exp_t.delete();
    k = inv ? N - 1 : 1;
    for (int l = 0; l < LOG_N; l++) begin
      len = inv ? (1 << l) : (N >> (l + 1));
      for (int s = 0; s < N; s += 2 * len) begin
        for (int j = s; j < s + len; j++) begin
          exp_a.push_back(j); exp_b.push_back(j + len); exp_t.push_back(k);
        end
        k = inv ? k - 1 : k + 1;
      end
    end
  endfunction

  function automatic logic pick_ready(input int stall_pct);
    if (stall_pct == 0) return 1'b1;
    return ($urandom_range(99) >= stall_pct) ? 1'b1 : 1'b0;
  endfunction

  task automatic run(input bit inv, input int stall_pct, input bit poke);
    int idx = 0, cyc = 1, resume = 1, last_hs = -100, done_cyc = -1;
    int stalls = 0, dut_wr = 0;
    int wq_c[$], wq_a[$], wq_b[$];
    bit finished = 0, pv_stall = 0;
    bit exp_valid, exp_done;
    logic [LOG_N-1:0] pa = '0, pb = '0, pt = '0;
    build(inv);
    @(posedge clk_i); #1;
    start_i = 1'b1; inverse_i = inv; ready_i = pick_ready(stall_pct);
    @(negedge clk_i);
    check("idle_busy", busy_o, 1'b0);
    @(posedge clk_i); #1;
    start_i = 1'b0; ready_i = pick_ready(stall_pct);
    while (!finished && cyc < 6000) begin
      @(negedge clk_i);
      exp_valid = (idx < TOTAL) && (cyc >= resume);
      exp_done  = (idx == TOTAL) && (cyc == last_hs + LAT + 1);
      check("valid", valid_o, exp_valid);
      check("done", done_o, exp_done);
      check("busy", busy_o, (done_cyc < 0));
      check("sel", sel_butterfly_o, inv);
      if (exp_valid) begin
        check("rd_a", rd_addr_a_o, exp_a[idx]);
        check("rd_b", rd_addr_b_o, exp_b[idx]);
        check("tw", tw_addr_o, exp_t[idx]);
        if (pv_stall) begin
          check("hold_a", rd_addr_a_o, pa);
          check("hold_b", rd_addr_b_o, pb);
          check("hold_tw", tw_addr_o, pt);
        end
        pa = rd_addr_a_o; pb = rd_addr_b_o; pt = tw_addr_o;
        if (ready_i) begin
          wq_c.push_back(cyc + LAT); wq_a.push_back(exp_a[idx]); wq_b.push_back(exp_b[idx]);
          idx++;
          last_hs = cyc;
          if (idx % HALF == 0) resume = cyc + LAT + 1;
          pv_stall = 0;
        end else begin
          stalls++;
          pv_stall = 1;
        end
      end
      if (wr_en_o === 1'b1) dut_wr++;
      if (wq_c.size() > 0 && wq_c[0] == cyc) begin
        check("wr_en", wr_en_o, 1'b1);
        check("wr_a", wr_addr_a_o, wq_a[0]);
        check("wr_b", wr_addr_b_o, wq_b[0]);
        void'(wq_c.pop_front()); void'(wq_a.pop_front()); void'(wq_b.pop_front());
      end else begin
        check("wr_idle", wr_en_o, 1'b0);
      end
      if (exp_done) done_cyc = cyc;
      if (done_cyc >= 0 && cyc == done_cyc + 1) finished = 1;
      if (!finished) begin
        @(posedge clk_i); #1;
        cyc++;
        ready_i   = pick_ready(stall_pct);
        start_i   = poke && (cyc == 300);
        inverse_i = (poke && cyc == 300) ? ~inv : inv;
      end
    end
    start_i = 1'b0;
    check("finished", finished, 1'b1);
    check("issued", idx, TOTAL);
    check("wr_count", dut_wr, TOTAL);
    check("done_time", done_cyc, 1 + LOG_N * (HALF + LAT) + stalls);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_done"}, done_o, 1'b0);
    check({tag, "_valid"}, valid_o, 1'b0);
    check({tag, "_rd_a"}, rd_addr_a_o, 0);
    check({tag, "_rd_b"}, rd_addr_b_o, 0);
    check({tag, "_tw"}, tw_addr_o, 0);
    check({tag, "_sel"}, sel_butterfly_o, 1'b0);
    check({tag, "_wr_en"}, wr_en_o, 1'b0);
    check({tag, "_wr_a"}, wr_addr_a_o, 0);
    check({tag, "_wr_b"}, wr_addr_b_o, 0);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; inverse_i = 1'b0; ready_i = 1'b1;
    @(negedge clk_i);
    check_quiet("rst");
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    run(1'b0, 0, 1'b0);
    run(1'b1, 0, 1'b0);
    run(1'b0, 30, 1'b0);
    run(1'b1, 40, 1'b1);

    // Reset mid-layer of a forward run, with write-backs still in flight.
    @(posedge clk_i); #1;
    start_i = 1'b1; inverse_i = 1'b0; ready_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int i = 0; i < 49; i++) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(negedge clk_i);
    check_quiet("midrst");
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check("post_rst_wr", wr_en_o, 1'b0);
      check("post_rst_busy", busy_o, 1'b0);
    end

    run(1'b0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
